instr_issue_queue: RTL
======================

// Module: instr_issue_queue
// PURPOSE
//  Upstream stage of the register-file/ALU datapath. Buffers 32-bit instruction words in a small FIFO.
//  Decodes each word into read indices RA/RB, write index RW and 3-bit ALU select s.
//  Issues at most one instruction per clk to the register file, inserting a bubble on read-after-write hazards.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of two, >= 2
//  CNT_W   16  width of issued-instruction counter
// PORTS
//  clk        in   1      clock; all state updates on posedge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      producer has an instruction on in_instr
//  in_ready   out  1      queue can accept; = !full (combinational)
//  in_instr   in   32     [17:15]=s, [14:10]=RA, [9:5]=RB, [4:0]=RW, [31:18] reserved
//  ex_stall   in   1      downstream busy; blocks issue this cycle
//  RA         out  5      read index A (registered)
//  RB         out  5      read index B (registered)
//  RW         out  5      write index (registered)
//  s          out  3      ALU op: 000 add,001 sub,010 mul,011 div,100 mod,101 and,110 or,111 xor
//  issue_valid out 1      RA/RB/RW/s hold a newly issued instruction this cycle
//  empty      out  1      FIFO empty
//  issue_cnt  out  CNT_W  instructions issued since reset; wraps 2^CNT_W-1 -> 0
// BEHAVIOUR
//  Reset (async, rst_n=0): RA=RB=RW=0, s=0, issue_valid=0, issue_cnt=0, FIFO pointers 0, state=IDLE.
//   in_ready=1 and empty=1 while in reset and after release. Reset mid-operation discards queued words.
//  Push: in_valid && in_ready at posedge writes in_instr to tail. When full, in_ready=0 even if a pop occurs
//   in the same cycle (no push-through-full).
//  Pop/issue conditions, all at one posedge: state!=IDLE, FIFO non-empty, !ex_stall, no hazard.
//   On issue: decoded fields -> output regs, issue_valid=1, head advances, issue_cnt+1.
//  Hazard: previous cycle had issue_valid=1 AND head RA or RB == last issued RW.
//   Response: one bubble cycle (issue_valid=0, fields held), then issue.
//  ex_stall=1: no pop, issue_valid=0 next cycle, fields held. Stall overrides hazard.
//   A pending bubble is consumed by the stall cycle.
//  Latency: word pushed into empty FIFO at edge N is issued at edge N+1 (outputs valid after N+1).
//  Simultaneous push+pop when not full: both occur, occupancy unchanged. Pointers wrap modulo DEPTH.
//  FSM:
//   IDLE   FIFO empty; issue_valid=0. -> ISSUE when occupancy>0.
//   ISSUE  issue if conditions met. -> BUBBLE on hazard; -> IDLE if last entry popped and no push.
//   BUBBLE exactly one cycle, issue_valid=0. -> ISSUE.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined:
//   Head word with any nonzero bit in [31:18] is popped without issue (issue_valid=0, issue_cnt unchanged).
//   Adds output ill_err (1 bit, reset 0), sticky until reset.
//  ILLEGAL_TRAP_EN undefined: bits [31:18] ignored; no ill_err port.
// TESTING
//  1. Reset, push 0x0000_4BE0 (s=000,RA=18,RB=31,RW=0) -> after next edge RA=18,RB=31,RW=0,s=0,
//     issue_valid=1 for 1 cycle, issue_cnt=1.
//  2. Back-to-back push RW=18 then RA=18 (s=001,RB=13) -> second issue one cycle late; one issue_valid=0 bubble between.
//  3. Hold ex_stall=1, push 5 words (DEPTH=4) -> in_ready=0 after 4th, 5th held; release stall
//     -> 4 issues in order, then in_ready=1.
//  4. Assert rst_n=0 with 3 queued mid-stream -> outputs 0, empty=1 immediately; no further issues.
//  5. Preload issue_cnt path with 2^16 issues -> issue_cnt wraps to 0.
//  6. (ILLEGAL_TRAP_EN) push 0x8000_0000 then valid word -> ill_err=1, only valid word issued, issue_cnt=1.

Source files
------------

// File: rtl/instr_issue_queue.sv
// Instruction issue queue: FIFO-buffers 32-bit words, decodes RA/RB/RW/s and issues one per clock,
// inserting a single bubble on read-after-write hazards. Optional ILLEGAL_TRAP_EN drops reserved-bit words.
module instr_issue_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             ex_stall,
  output logic [4:0]       RA,
  output logic [4:0]       RB,
  output logic [4:0]       RW,
  output logic [2:0]       s,
  output logic             issue_valid,
  output logic             empty,
  output logic [CNT_W-1:0] issue_cnt
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic             ill_err
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, BUBBLE} state_t;

  state_t        state, state_nx;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0]   count, count_nx;
  logic [31:0]   head_word;
  logic [4:0]    h_ra, h_rb, h_rw;
  logic [2:0]    h_s;
  logic          full, push, pop, can_pop, hazard, head_ill, do_issue;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;

  assign head_word = mem[head];
  assign h_s       = head_word[17:15];
  assign h_ra      = head_word[14:10];
  assign h_rb      = head_word[9:5];
  assign h_rw      = head_word[4:0];

`ifdef ILLEGAL_TRAP_EN
  assign head_ill = |head_word[31:18];
`else
  logic unused_rsvd;
  assign unused_rsvd = ^head_word[31:18];
  assign head_ill    = 1'b0;
`endif

  // The hazard only exists while the previous issue is still visible on the outputs,
  // so a stall or bubble cycle (issue_valid low) clears it automatically.
  assign hazard   = issue_valid && ((h_ra == RW) || (h_rb == RW));
  assign can_pop  = (state != IDLE) && !empty && !ex_stall;
  assign do_issue = can_pop && !head_ill && !hazard;
  assign pop      = can_pop && (head_ill || !hazard);

  always_comb begin
    count_nx = count;
    if (push && !pop)
      count_nx = count + (AW+1)'(1);
    else if (!push && pop)
      count_nx = count - (AW+1)'(1);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (count_nx != '0)
          state_nx = ISSUE;
      end
      ISSUE, BUBBLE: begin
        if (count_nx == '0)
          state_nx = IDLE;
        else if (can_pop && !head_ill && hazard)
          state_nx = BUBBLE;
        else
          state_nx = ISSUE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[tail] <= in_instr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      RA          <= '0;
      RB          <= '0;
      RW          <= '0;
      s           <= '0;
      issue_valid <= 1'b0;
      issue_cnt   <= '0;
    end else begin
      state       <= state_nx;
      count       <= count_nx;
      issue_valid <= do_issue;
      if (push)
        tail <= tail + AW'(1);
      if (pop)
        head <= head + AW'(1);
      if (do_issue) begin
        RA        <= h_ra;
        RB        <= h_rb;
        RW        <= h_rw;
        s         <= h_s;
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ill_err <= 1'b0;
    else if (can_pop && head_ill)
      ill_err <= 1'b1;
  end
`endif

endmodule
